// File: rtl/weighted_sum_vote.sv
// Multi-channel weighted-sum voter: captures one frame of six feature flags per
// channel, scores the channels serially, and reports total score, votes and detect.
`timescale 1ns/1ps
module weighted_sum_vote #(
  parameter int NUM_CH   = 16,
  parameter int W_W      = 12,
  parameter int LL_W     = 18,
  parameter int NE_W     = 39,
  parameter int PS_W     = -7,
  parameter int THETA_W  = 382,
  parameter int ALPHA_W  = 64,
  parameter int BETA_W   = 68,
  parameter int THRESH   = 400,
  parameter int VOTE_MIN = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [6*NUM_CH-1:0]                   in_feat,
  input  logic [NUM_CH-1:0]                     in_mask,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic signed [W_W+$clog2(NUM_CH)-1:0]  total_sum,
  output logic [$clog2(NUM_CH+1)-1:0]           vote_cnt,
  output logic                                  detect,
  output logic [1:0]                            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high only in IDLE; out_valid holds with stable data until out_ready.

  localparam int SUM_W = W_W + $clog2(NUM_CH);
  localparam int CNT_W = $clog2(NUM_CH + 1);
  localparam int IDX_W = $clog2(NUM_CH);

  // Index k of this array is the weight of feature bit k (ll first).
  localparam logic [5:0][W_W-1:0] WT = {W_W'(BETA_W), W_W'(ALPHA_W), W_W'(THETA_W),
                                        W_W'(PS_W), W_W'(NE_W), W_W'(LL_W)};
  localparam logic signed [W_W-1:0] THRESH_S = W_W'(THRESH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          ch_idx_q, ch_idx_d;
  logic [6*NUM_CH-1:0]       feat_q, feat_d;
  logic [NUM_CH-1:0]         mask_q, mask_d;
  logic signed [SUM_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          vote_q, vote_d;
  logic signed [SUM_W-1:0]   total_sum_q, total_sum_d;
  logic [CNT_W-1:0]          vote_cnt_q, vote_cnt_d;
  logic                      detect_q, detect_d;
  logic                      out_valid_q, out_valid_d;

  logic [5:0]                ch_feat;
  logic signed [W_W-1:0]     score;
  logic                      ch_en;
  logic signed [SUM_W-1:0]   acc_nx;
  logic [CNT_W-1:0]          vote_nx;

  always_comb begin
    state_d     = state_q;
    ch_idx_d    = ch_idx_q;
    feat_d      = feat_q;
    mask_d      = mask_q;
    acc_d       = acc_q;
    vote_d      = vote_q;
    total_sum_d = total_sum_q;
    vote_cnt_d  = vote_cnt_q;
    detect_d    = detect_q;
    out_valid_d = out_valid_q;

    ch_feat = feat_q[6*ch_idx_q +: 6];
    score   = '0;
    for (int k = 0; k < 6; k++) begin
      if (ch_feat[k]) score = score + $signed(WT[k]);
    end
    ch_en   = mask_q[ch_idx_q];
    acc_nx  = ch_en ? acc_q + SUM_W'(score) : acc_q;
    vote_nx = vote_q + CNT_W'(ch_en && (score >= THRESH_S));

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          feat_d   = in_feat;
          mask_d   = in_mask;
          acc_d    = '0;
          vote_d   = '0;
          ch_idx_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d  = acc_nx;
        vote_d = vote_nx;
        if (ch_idx_q == IDX_W'(NUM_CH - 1)) begin
          total_sum_d = acc_nx;
          vote_cnt_d  = vote_nx;
          detect_d    = int'(vote_nx) >= VOTE_MIN;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          ch_idx_d = ch_idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_idx_q    <= '0;
      feat_q      <= '0;
      mask_q      <= '0;
      acc_q       <= '0;
      vote_q      <= '0;
      total_sum_q <= '0;
      vote_cnt_q  <= '0;
      detect_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_idx_q    <= ch_idx_d;
      feat_q      <= feat_d;
      mask_q      <= mask_d;
      acc_q       <= acc_d;
      vote_q      <= vote_d;
      total_sum_q <= total_sum_d;
      vote_cnt_q  <= vote_cnt_d;
      detect_q    <= detect_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign total_sum = total_sum_q;
  assign vote_cnt  = vote_cnt_q;
  assign detect    = detect_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_weighted_sum_vote.sv
// Bench for weighted_sum_vote: directed frames from the test plan plus random
// frames, scored against a plain-arithmetic reference through an expected queue.
`timescale 1ns/1ps
module tb_weighted_sum_vote;
  localparam int NUM_CH = 16;
  localparam int SUM_W  = 16;
  localparam int CNT_W  = 5;
  localparam int EXP_W  = SUM_W + CNT_W + 1;

  logic                     clk;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic [6*NUM_CH-1:0]      in_feat;
  logic [NUM_CH-1:0]        in_mask;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [SUM_W-1:0]  total_sum;
  logic [CNT_W-1:0]         vote_cnt;
  logic                     detect;
  logic [1:0]               dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int accept_cyc = 0;
  bit rand_rdy = 0;
  logic [EXP_W-1:0] exp_q[$];

  weighted_sum_vote dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_feat(in_feat), .in_mask(in_mask), .out_valid(out_valid),
    .out_ready(out_ready), .total_sum(total_sum), .vote_cnt(vote_cnt),
    .detect(detect), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [EXP_W-1:0] model(input logic [6*NUM_CH-1:0] f,
                                             input logic [NUM_CH-1:0] m);
    int w[6] = '{18, 39, -7, 382, 64, 68};
    int sum = 0;
    int cnt = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      int s = 0;
      for (int k = 0; k < 6; k++) if (f[6*c+k]) s += w[k];
      if (m[c]) begin
        sum += s;
        if (s >= 400) cnt++;
      end
    end
    return {SUM_W'(sum), CNT_W'(cnt), cnt >= 4};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [6*NUM_CH-1:0] f, input logic [NUM_CH-1:0] m);
    int b = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_feat  = f;
    in_mask  = m;
    #1;
    while (!in_ready && b < 200) begin
      @(negedge clk); #1; b++;
    end
    if (!in_ready) begin
      check("send_in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(f, m));
    @(posedge clk);
    @(negedge clk);
    accept_cyc = cyc;
    in_valid   = 1'b0;
    in_feat    = {$urandom, $urandom, $urandom};
  endtask

  task automatic wait_idle();
    int b = 0;
    while (exp_q.size() != 0 && b < 400) begin
      @(negedge clk); b++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  function automatic logic [6*NUM_CH-1:0] rep(input logic [5:0] lo, input logic [5:0] hi,
                                              input int n_lo);
    logic [6*NUM_CH-1:0] f;
    for (int c = 0; c < NUM_CH; c++) f[6*c +: 6] = (c < n_lo) ? lo : hi;
    return f;
  endfunction

  always @(negedge clk) if (rand_rdy) out_ready = 1'($urandom_range(0, 1));

  // ---------------- scoreboard / monitor ----------------
  logic                    prev_valid = 1'b0;
  logic                    prev_ready = 1'b0;
  logic signed [SUM_W-1:0] prev_sum;
  logic [CNT_W-1:0]        prev_cnt;
  logic                    prev_det;

  always @(negedge clk) begin
    #3;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        check("in_ready_low_in_done", int'(in_ready), 0);
        if (!prev_valid) begin
          check("latency", cyc - accept_cyc, NUM_CH);
        end else if (!prev_ready) begin
          check("hold_sum", int'(total_sum), int'(prev_sum));
          check("hold_cnt", int'(vote_cnt), int'(prev_cnt));
          check("hold_det", int'(detect), int'(prev_det));
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            logic [EXP_W-1:0] e;
            e = exp_q.pop_front();
            check("total_sum", int'(total_sum), int'($signed(e[EXP_W-1 -: SUM_W])));
            check("vote_cnt", int'(vote_cnt), int'(e[CNT_W:1]));
            check("detect", int'(detect), int'(e[0]));
          end
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_sum   = total_sum;
      prev_cnt   = vote_cnt;
      prev_det   = detect;
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    logic [6*NUM_CH-1:0] fa;
    logic [NUM_CH-1:0]   m;
    int b;
    rst_n = 1'b0; in_valid = 1'b0; in_feat = '0; in_mask = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_total_sum", int'(total_sum), 0);
    check("rst_vote_cnt", int'(vote_cnt), 0);
    check("rst_detect", int'(detect), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed frames
    send('0, '1);                                  wait_idle();
    send('1, '1);                                  wait_idle();
    send(rep(6'b000100, 6'b000100, 0), '1);        wait_idle();
    send(rep(6'b011000, 6'b001000, 4), '1);        wait_idle();
    send(rep(6'b011000, 6'b001000, 4), 16'hFFF7);  wait_idle();

    // back-pressure: DONE held with in_valid high and in_feat changing
    out_ready = 1'b0;
    fa = {$urandom, $urandom, $urandom};
    send(fa, 16'hF0F3);
    b = 0;
    while (!out_valid && b < 100) begin
      @(negedge clk); #1; b++;
    end
    check("done_reached", int'(out_valid), 1);
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_feat  = {$urandom, $urandom, $urandom};
      #1;
      check("frozen_in_ready", int'(in_ready), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("in_ready_after_hs", int'(in_ready), 1);
    in_feat = rep(6'b111011, 6'b000001, 9);
    in_mask = '1;
    exp_q.push_back(model(in_feat, in_mask));
    @(posedge clk);
    @(negedge clk);
    accept_cyc = cyc;
    in_valid = 1'b0;
    wait_idle();

    // reset in the middle of a frame
    send('1, 16'h7FFF);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_total_sum", int'(total_sum), 0);
    check("midrst_vote_cnt", int'(vote_cnt), 0);
    check("midrst_detect", int'(detect), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst_in_ready", int'(in_ready), 1);
    send('1, '1);
    wait_idle();

    // random frames with random back-pressure
    rand_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0:       m = '0;
        1:       m = '1;
        default: m = NUM_CH'($urandom);
      endcase
      send({$urandom, $urandom, $urandom}, m);
    end
    wait_idle();
    rand_rdy = 0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
